melody_sequencer: RTL and testbench



---
 rtl/melody_sequencer.sv | 174 +++++++++++++++++
 tb/tb_melody_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a fixed 16-step song by driving a one-hot
// enable toward the per-note tone generators. Each step holds its note
// for dur*BEAT_CYCLES cycles, and the last GAP_CYCLES of that time are
// silent so that repeated notes are heard as separate notes.
//
// Handshake: there is none. play, stop and loop are plain levels that are
// sampled on every rising clk edge. All outputs come from flops and
// change only on a clk edge.
module melody_sequencer #(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       play,
    input  logic       stop,
    input  logic       loop,
    output logic [6:0] note_en,
    output logic       busy,
    output logic [3:0] step,
    output logic       done,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [31:0] BEAT32   = 32'(BEAT_CYCLES);
    localparam logic [31:0] GAP32    = 32'(GAP_CYCLES);
    localparam logic [2:0]  CODE_REST = 3'd7;

    // Song table. Each entry is {note code, duration in beats}.
    // Codes 0..6 are C..B and code 7 is a rest.
    function automatic logic [5:0] song_rom(input logic [3:0] idx);
        logic [5:0] e;
        case (idx)
            4'd0:    e = {3'd2, 3'd1};  // E
            4'd1:    e = {3'd2, 3'd1};  // E
            4'd2:    e = {3'd3, 3'd1};  // F
            4'd3:    e = {3'd4, 3'd1};  // G
            4'd4:    e = {3'd4, 3'd1};  // G
            4'd5:    e = {3'd3, 3'd1};  // F
            4'd6:    e = {3'd2, 3'd1};  // E
            4'd7:    e = {3'd1, 3'd1};  // D
            4'd8:    e = {3'd0, 3'd1};  // C
            4'd9:    e = {3'd0, 3'd1};  // C
            4'd10:   e = {3'd1, 3'd1};  // D
            4'd11:   e = {3'd2, 3'd1};  // E
            4'd12:   e = {3'd2, 3'd2};  // E, two beats
            4'd13:   e = {3'd1, 3'd1};  // D
            4'd14:   e = {3'd1, 3'd2};  // D, two beats
            default: e = {CODE_REST, 3'd1};  // closing rest
        endcase
        return e;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [31:0] cnt_q, cnt_d;
    logic [6:0]  note_en_q, note_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [5:0]  cur_entry;
    logic [5:0]  nxt_entry;
    logic [31:0] step_len;
    logic [31:0] note_len;
    logic        song_end;

    // Step length of the current step, measured at 32-bit width.
    always_comb begin
        cur_entry = song_rom(step_q);
        step_len  = {29'd0, cur_entry[2:0]} * BEAT32;
        note_len  = step_len - GAP32;
    end

    // State register: the FSM flops and all output flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            step_q    <= 4'd0;
            cnt_q     <= 32'd0;
            note_en_q <= 7'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            note_en_q <= note_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state. stop overrides everything except reset. cnt_q counts
    // cycles from the start of the current step.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        song_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (play && !stop) begin
                    state_d = ST_NOTE;
                    step_d  = 4'd0;
                    cnt_d   = 32'd0;
                end
            end
            ST_NOTE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    step_d  = 4'd0;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q == note_len - 32'd1) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    step_d  = 4'd0;
                    cnt_d   = 32'd0;
                end else if (cnt_q == step_len - 32'd1) begin
                    cnt_d = 32'd0;
                    if (step_q != 4'd15) begin
                        state_d = ST_NOTE;
                        step_d  = step_q + 4'd1;
                    end else if (loop) begin
                        state_d = ST_NOTE;
                        step_d  = 4'd0;
                    end else begin
                        state_d  = ST_IDLE;
                        step_d   = 4'd0;
                        song_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = 4'd0;
                cnt_d   = 32'd0;
            end
        endcase
    end

    // Outputs are computed from the next state so that the registered
    // values line up with the state they describe.
    always_comb begin
        nxt_entry = song_rom(step_d);
        note_en_d = 7'd0;
        if (state_d == ST_NOTE && nxt_entry[5:3] != CODE_REST) begin
            note_en_d = 7'd1 << nxt_entry[5:3];
        end
        busy_d = (state_d != ST_IDLE);
        done_d = song_end;
    end

    assign note_en   = note_en_q;
    assign busy      = busy_q;
    assign step      = step_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Testbench for melody_sequencer with BEAT_CYCLES=10 and GAP_CYCLES=2.
// The drive_vec task sets the inputs on a falling edge and pushes the
// expected outputs for the cycle after the next rising edge. The monitor
// process checks the outputs 1 time unit after each rising edge.
// Expected vector layout: {note_en[6:0], busy, step[3:0], done}.
module tb_melody_sequencer;

  localparam int BEAT = 10;
  localparam int GAP  = 2;
  localparam int SONG = 180;

  localparam int CODE_T [16] = '{2, 2, 3, 4, 4, 3, 2, 1, 0, 0, 1, 2, 2, 1, 1, 7};
  localparam int DUR_T  [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 2, 1};

  localparam logic [12:0] EXP_IDLE = 13'd0;
  localparam logic [12:0] EXP_DONE = 13'd1;

  logic       clk;
  logic       rst_n;
  logic       play;
  logic       stop;
  logic       loop;
  logic [6:0] note_en;
  logic       busy;
  logic [3:0] step;
  logic       done;
  logic [1:0] state_dbg;

  logic [12:0] exp_q[$];
  string       name_q[$];
  int          n_vec;
  int          n_miss;

  melody_sequencer #(
    .BEAT_CYCLES(BEAT),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .play     (play),
    .stop     (stop),
    .loop     (loop),
    .note_en  (note_en),
    .busy     (busy),
    .step     (step),
    .done     (done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n = 1'b0;
    play  = 1'b0;
    stop  = 1'b0;
    loop  = 1'b0;
  end

  // Expected outputs for cycle t after play was sampled (t >= 1). The song
  // repeats every SONG cycles, which is what looping produces.
  function automatic logic [12:0] song_exp(input int t);
    int k;
    int len;
    logic [6:0] ne;
    logic [3:0] s4;
    k = (t - 1) % SONG;
    for (int s = 0; s < 16; s++) begin
      len = DUR_T[s] * BEAT;
      if (k < len) begin
        ne = 7'd0;
        if (k < len - GAP && CODE_T[s] != 7) ne = 7'd1 << CODE_T[s];
        s4 = 4'(s);
        return {ne, 1'b1, s4, 1'b0};
      end
      k = k - len;
    end
    return EXP_IDLE;
  endfunction

  // driver
  task automatic drive_vec(input logic p, input logic s, input logic l,
                           input logic r, input logic [12:0] e,
                           input string nm);
    @(negedge clk);
    play  = p;
    stop  = s;
    loop  = l;
    rst_n = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  initial begin
    logic [12:0] got;
    logic [12:0] want;
    string       nm;
    n_vec  = 0;
    n_miss = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        got  = {note_en, busy, step, done};
        n_vec++;
        if (got !== want) begin
          n_miss++;
          $display("FAIL %s vec%0d: got note_en=%b busy=%b step=%0d done=%b, want note_en=%b busy=%b step=%0d done=%b",
                   nm, n_vec, got[12:6], got[5], got[4:1], got[0],
                   want[12:6], want[5], want[4:1], want[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic l;
    int   wait_cnt;

    // reset state
    for (int i = 0; i < 3; i++) drive_vec(1'b0, 1'b0, 1'b0, 1'b0, EXP_IDLE, "reset");

    // A: full song without looping. loop toggles freely except at the
    // step-15 gap end. play is then held high from the last gap cycle and
    // restarts the song right after done.
    drive_vec(1'b1, 1'b0, 1'b0, 1'b1, song_exp(1), "a_start");
    for (int i = 1; i < SONG; i++) begin
      l = 1'($urandom_range(0, 1));
      drive_vec(1'b0, 1'b0, l, 1'b1, song_exp(i + 1), "a_song");
    end
    drive_vec(1'b1, 1'b0, 1'b0, 1'b1, EXP_DONE, "a_done");
    for (int i = 181; i < 196; i++)
      drive_vec(1'b1, 1'b0, 1'b0, 1'b1, song_exp(i - 180), "a_replay");
    drive_vec(1'b0, 1'b1, 1'b0, 1'b1, EXP_IDLE, "a_stop");
    drive_vec(1'b0, 1'b0, 1'b0, 1'b1, EXP_IDLE, "a_idle");

    // B: loop high at the song end wraps the song back to step 0.
    drive_vec(1'b1, 1'b0, 1'b0, 1'b1, song_exp(1), "b_start");
    for (int i = 1; i < 200; i++) begin
      l = (i == SONG) ? 1'b1 : 1'($urandom_range(0, 1));
      drive_vec(1'b0, 1'b0, l, 1'b1, song_exp(i + 1), "b_loop");
    end
    drive_vec(1'b0, 1'b1, 1'b0, 1'b1, EXP_IDLE, "b_stop");

    // C: stop in the middle of step 4, then play and stop together.
    drive_vec(1'b1, 1'b0, 1'b0, 1'b1, song_exp(1), "c_start");
    for (int i = 1; i < 45; i++)
      drive_vec(1'b0, 1'b0, 1'b0, 1'b1, song_exp(i + 1), "c_song");
    drive_vec(1'b0, 1'b1, 1'b0, 1'b1, EXP_IDLE, "c_stop");
    for (int i = 46; i < 50; i++)
      drive_vec(1'b0, 1'b0, 1'b0, 1'b1, EXP_IDLE, "c_idle");
    drive_vec(1'b1, 1'b1, 1'b0, 1'b1, EXP_IDLE, "c_play_stop");
    for (int i = 51; i < 54; i++)
      drive_vec(1'b0, 1'b0, 1'b0, 1'b1, EXP_IDLE, "c_idle2");

    // D: play while busy is ignored, then a mid-song reset and a fresh start.
    drive_vec(1'b1, 1'b0, 1'b0, 1'b1, song_exp(1), "d_start");
    for (int i = 1; i < 60; i++)
      drive_vec((i >= 30 && i < 36), 1'b0, 1'b0, 1'b1, song_exp(i + 1), "d_busy_play");
    drive_vec(1'b0, 1'b0, 1'b0, 1'b0, EXP_IDLE, "d_reset");
    drive_vec(1'b1, 1'b0, 1'b0, 1'b1, song_exp(1), "d_restart");
    for (int i = 62; i < 90; i++)
      drive_vec(1'b0, 1'b0, 1'b0, 1'b1, song_exp(i - 60), "d_song");

    // drain the scoreboard within a bounded number of cycles
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
